dds_param_sched: RTL
====================

Name: dds_param_sched

Overview:
Parameter scheduler for the DDS waveform datapath. It turns debounced key pulses into the datapath's control inputs: wave_sel, freq, phase_ctrl and key_flag. It supports a manual mode and an automatic triangular frequency sweep. It sits between the key-filter blocks and the DDS datapath, and all outputs are registered.

Parameters:
FREQ_MIN, 7'd20, lowest frequency code (manual and sweep)
FREQ_MAX, 7'd100, highest frequency code (manual and sweep)
FREQ_STEP, 7'd5, frequency code increment per key press or sweep step
DWELL_CYC, 32'd50_000_000, sys_clk cycles spent at each sweep frequency (must be >= 2)
PHASE_STEP, 5'd8, value driven on phase_ctrl

Ports:
sys_clk        input   1  system clock, 50 MHz
sys_rst_n      input   1  asynchronous reset, active-low
key_wave       input   1  one-cycle pulse: advance waveform
key_freq_up    input   1  one-cycle pulse: raise frequency (manual mode only)
key_freq_dn    input   1  one-cycle pulse: lower frequency (manual mode only)
key_phase      input   1  one-cycle pulse: request phase advance
key_sweep      input   1  one-cycle pulse: toggle auto sweep
wave_sel       output  4  one-hot waveform select (0001 sin, 0010 squ, 0100 tri, 1000 saw)
freq           output  7  frequency code to the datapath
phase_ctrl     output  5  phase increment, constant PHASE_STEP
key_flag       output  1  one-cycle phase-advance strobe to the datapath
sweep_active   output  1  high while in either sweep state

Behaviour:
- Clock/reset: reset sys_rst_n, asynchronous, active-low; clock sys_clk.
- Reset values:
  - wave_sel=4'b0001, freq=FREQ_MIN, phase_ctrl=PHASE_STEP
  - key_flag=0, sweep_active=0
  - state=MANUAL, dwell counter=0
- Latency: every output reflects a key pulse on the sys_clk edge after the pulse is sampled (1 cycle).
- wave_sel:
  - key_wave rotates the one-hot value left: 0001->0010->0100->1000->0001.
  - Active in every state.
  - If wave_sel is ever non-one-hot, the next key_wave forces 0001.
- key_flag: registered copy of key_phase (a 1-cycle pulse delayed 1 cycle). Independent of state.
- FSM states: MANUAL, SWEEP_UP, SWEEP_DN.
- MANUAL:
  - key_freq_up: freq = min(freq+FREQ_STEP, FREQ_MAX).
  - key_freq_dn: freq = max(freq-FREQ_STEP, FREQ_MIN).
  - Compute sums and differences 8 bits wide, so there is no 7-bit wrap.
  - key_sweep -> SWEEP_UP; dwell counter cleared; freq unchanged.
- SWEEP_UP / SWEEP_DN:
  - Dwell counter counts 0..DWELL_CYC-1. At terminal count it returns to 0 and a step occurs.
  - SWEEP_UP step: if freq+FREQ_STEP >= FREQ_MAX then freq=FREQ_MAX and go to SWEEP_DN, else freq += FREQ_STEP.
  - SWEEP_DN step: if freq <= FREQ_MIN+FREQ_STEP then freq=FREQ_MIN and go to SWEEP_UP, else freq -= FREQ_STEP.
  - key_freq_up and key_freq_dn are ignored.
  - key_sweep -> MANUAL; freq holds its current value; dwell counter cleared.
- sweep_active = (state != MANUAL), registered with the state.
- Simultaneous events:
  - key_sweep takes priority over freq keys in the same cycle. The freq keys are dropped.
  - key_freq_up together with key_freq_dn: no change.
  - key_sweep arriving on a dwell terminal-count cycle: the toggle wins and no step occurs.
  - key_wave and key_phase are orthogonal and always honoured.
- Frequency range:
  - If freq is outside [FREQ_MIN, FREQ_MAX], the next update clamps it into range.
  - Codes not on the FREQ_STEP grid are legal and pass through; the datapath handles them with its default formula.
- Reset mid-sweep returns immediately and asynchronously to the reset values.

Decomposition:
- Shared package dds_pkg holds:
  - waveform one-hot constants WAVE_SIN, WAVE_SQU, WAVE_TRI, WAVE_SAW
  - state encoding for MANUAL, SWEEP_UP, SWEEP_DN
  - default FREQ_MIN, FREQ_MAX, FREQ_STEP
- One sub-module, dds_dwell_timer:
  - Inputs: clear, enable.
  - Output: 1-cycle tick at DWELL_CYC-1.
  - Parameter: DWELL_CYC.

Test Plan (bench uses DWELL_CYC=4):
1. Reset, then 3 key_wave pulses, then 2 more -> wave_sel goes 0001, 0010, 0100, 1000, then 0001, 0010. Each change lands 1 cycle after its pulse.
2. 20 key_freq_up pulses -> freq steps 25, 30, ... 100 and stays at 100. Then 20 key_freq_dn pulses -> freq steps down to 20 and stays at 20.
3. Start with freq=90 and send key_sweep -> sweep_active=1. freq=95 after 4 cycles, 100 after 8 cycles (state SWEEP_DN), 95 after 12 cycles.
4. During the sweep, pulse key_freq_up -> freq unaffected. Then key_sweep on a dwell terminal-count cycle -> state MANUAL, sweep_active=0, freq holds with no step.
5. key_phase pulse -> key_flag=1 for exactly 1 cycle, 1 cycle later, with phase_ctrl=8. key_freq_up and key_freq_dn in the same cycle -> freq unchanged.
6. Assert sys_rst_n low mid-sweep with freq=60, wave_sel=0100 -> all outputs return to their reset values asynchronously. After release, no step occurs until a new key_sweep.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants for the DDS parameter scheduler: waveform one-hot codes,
// scheduler state encoding and default frequency limits.
package dds_pkg;

    localparam logic [3:0] WAVE_SIN = 4'b0001;
    localparam logic [3:0] WAVE_SQU = 4'b0010;
    localparam logic [3:0] WAVE_TRI = 4'b0100;
    localparam logic [3:0] WAVE_SAW = 4'b1000;

    localparam logic [1:0] ST_MANUAL   = 2'd0;
    localparam logic [1:0] ST_SWEEP_UP = 2'd1;
    localparam logic [1:0] ST_SWEEP_DN = 2'd2;

    localparam logic [6:0] DFLT_FREQ_MIN  = 7'd20;
    localparam logic [6:0] DFLT_FREQ_MAX  = 7'd100;
    localparam logic [6:0] DFLT_FREQ_STEP = 7'd5;

    // Any code that is not a legal one-hot value recovers to sine.
    function automatic logic [3:0] wave_rotate(input logic [3:0] w);
        case (w)
            WAVE_SIN: return WAVE_SQU;
            WAVE_SQU: return WAVE_TRI;
            WAVE_TRI: return WAVE_SAW;
            default:  return WAVE_SIN;
        endcase
    endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer for the frequency sweep: counts 0..DWELL_CYC-1 while enabled and
// pulses o_tick on the terminal count.
module dds_dwell_timer #(
    parameter logic [31:0] DWELL_CYC = 32'd50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    logic [31:0] r_cnt;
    logic        w_terminal;

    assign w_terminal = (r_cnt == (DWELL_CYC - 32'd1));
    // A clear on the terminal cycle suppresses the tick so a mode toggle never steps.
    assign o_tick     = i_enable & ~i_clear & w_terminal;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_terminal ? 32'd0 : (r_cnt + 32'd1);
        end
    end

endmodule

// File: rtl/dds_param_sched.sv
// DDS parameter scheduler: maps debounced key pulses to wave_sel, freq,
// phase_ctrl and key_flag, with a manual mode and a triangular auto sweep.
module dds_param_sched
    import dds_pkg::*;
#(
    parameter logic [6:0]  FREQ_MIN   = DFLT_FREQ_MIN,
    parameter logic [6:0]  FREQ_MAX   = DFLT_FREQ_MAX,
    parameter logic [6:0]  FREQ_STEP  = DFLT_FREQ_STEP,
    parameter logic [31:0] DWELL_CYC  = 32'd50_000_000,
    parameter logic [4:0]  PHASE_STEP = 5'd8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_wave,
    input  logic       key_freq_up,
    input  logic       key_freq_dn,
    input  logic       key_phase,
    input  logic       key_sweep,
    output logic [3:0] wave_sel,
    output logic [6:0] freq,
    output logic [4:0] phase_ctrl,
    output logic       key_flag,
    output logic       sweep_active
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [6:0] r_freq;
    logic [6:0] w_freq_nxt;
    logic [3:0] r_wave_sel;
    logic [4:0] r_phase_ctrl;
    logic       r_key_flag;
    logic       r_sweep_active;
    logic       w_tick;
    logic [7:0] w_sum;
    logic [7:0] w_diff;
    logic [7:0] w_floor;

    function automatic logic [6:0] clamp_freq(input logic [7:0] v);
        if (v > {1'b0, FREQ_MAX}) return FREQ_MAX;
        if (v < {1'b0, FREQ_MIN}) return FREQ_MIN;
        return v[6:0];
    endfunction

    // 8-bit arithmetic; the difference floors at 0 so it can never wrap.
    assign w_sum   = {1'b0, r_freq} + {1'b0, FREQ_STEP};
    assign w_diff  = (r_freq >= FREQ_STEP) ? ({1'b0, r_freq} - {1'b0, FREQ_STEP}) : 8'd0;
    assign w_floor = {1'b0, FREQ_MIN} + {1'b0, FREQ_STEP};

    dds_dwell_timer #(
        .DWELL_CYC (DWELL_CYC)
    ) u_dwell (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_clear   (key_sweep),
        .i_enable  (r_state != ST_MANUAL),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        if (key_sweep) begin
            w_state_nxt = (r_state == ST_MANUAL) ? ST_SWEEP_UP : ST_MANUAL;
        end else begin
            case (r_state)
                ST_MANUAL: begin
                    if (key_freq_up && !key_freq_dn) begin
                        w_freq_nxt = clamp_freq(w_sum);
                    end else if (key_freq_dn && !key_freq_up) begin
                        w_freq_nxt = clamp_freq(w_diff);
                    end
                end
                ST_SWEEP_UP: begin
                    if (w_tick) begin
                        if (w_sum >= {1'b0, FREQ_MAX}) begin
                            w_freq_nxt  = FREQ_MAX;
                            w_state_nxt = ST_SWEEP_DN;
                        end else begin
                            w_freq_nxt = clamp_freq(w_sum);
                        end
                    end
                end
                ST_SWEEP_DN: begin
                    if (w_tick) begin
                        if ({1'b0, r_freq} <= w_floor) begin
                            w_freq_nxt  = FREQ_MIN;
                            w_state_nxt = ST_SWEEP_UP;
                        end else begin
                            w_freq_nxt = clamp_freq(w_diff);
                        end
                    end
                end
                default: w_state_nxt = ST_MANUAL;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state        <= ST_MANUAL;
            r_sweep_active <= 1'b0;
            r_freq         <= FREQ_MIN;
            r_wave_sel     <= WAVE_SIN;
            r_key_flag     <= 1'b0;
            r_phase_ctrl   <= PHASE_STEP;
        end else begin
            r_state        <= w_state_nxt;
            r_sweep_active <= (w_state_nxt != ST_MANUAL);
            r_freq         <= w_freq_nxt;
            r_key_flag     <= key_phase;
            r_phase_ctrl   <= PHASE_STEP;
            if (key_wave) begin
                r_wave_sel <= wave_rotate(r_wave_sel);
            end
        end
    end

    assign wave_sel     = r_wave_sel;
    assign freq         = r_freq;
    assign phase_ctrl   = r_phase_ctrl;
    assign key_flag     = r_key_flag;
    assign sweep_active = r_sweep_active;

endmodule
